div_sequencer: RTL and testbench

- Multi-cycle iterative divider with a start/done handshake. It replaces the single-cycle combinational divide in the ARM datapath when timing closure needs it.
- Restoring radix-2 algorithm, one quotient bit per clock.
- Result semantics match the existing divider:
  - op=0: signed divide, truncating toward zero.
  - op=1: magnitude divide, |rn|/|rm|.
- The core controller stalls the PC/register write while busy is high.

---
 rtl/div_pkg.sv | 15 +
 rtl/absolute_value.sv | 11 +
 rtl/div_step.sv | 19 +
 rtl/div_sequencer.sv | 111 +++++++++++
 tb/tb_div_sequencer.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int   DEF_WIDTH = 32;
   localparam logic OP_SIGNED = 1'b0;
   localparam logic OP_MAG    = 1'b1;

endpackage

// File: rtl/absolute_value.sv
// Two's-complement absolute value; the most negative input maps to itself read as unsigned.
module absolute_value #(
   parameter int WIDTH = 32
) (
   input  logic signed [WIDTH-1:0] i_val,
   output logic        [WIDTH-1:0] o_abs
);

   assign o_abs = i_val[WIDTH-1] ? $unsigned(-i_val) : $unsigned(i_val);

endmodule

// File: rtl/div_step.sv
// One restoring radix-2 step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic             i_dvd_msb,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_q
);

   logic [WIDTH:0] w_shift;

   assign w_shift = {i_rem, i_dvd_msb};
   assign o_q     = (w_shift >= {1'b0, i_divisor});
   // When the divisor fits, the difference is below the divisor, so WIDTH bits hold it exactly.
   assign o_rem   = o_q ? (w_shift[WIDTH-1:0] - i_divisor) : w_shift[WIDTH-1:0];

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider with start/valid/ack handshake; one quotient bit per clock.
module div_sequencer
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             start_ready,
   input  logic [WIDTH-1:0] rn,
   input  logic [WIDTH-1:0] rm,
   input  logic             op,
   output logic [WIDTH-1:0] y,
   output logic             valid,
   input  logic             ack,
   output logic             busy,
   output logic             div_zero
);

   state_t           r_state;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_divisor;
   logic [WIDTH-1:0] r_y;
   logic [CNT_W-1:0] r_cnt;
   logic             r_op;
   logic             r_sign;
   logic             r_valid;
   logic             r_div_zero;

   logic [WIDTH-1:0] w_abs_rn;
   logic [WIDTH-1:0] w_abs_rm;
   logic [WIDTH-1:0] w_rem_nxt;
   logic             w_q;

   absolute_value #(.WIDTH(WIDTH)) u_abs_rn (.i_val(rn), .o_abs(w_abs_rn));
   absolute_value #(.WIDTH(WIDTH)) u_abs_rm (.i_val(rm), .o_abs(w_abs_rm));

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem     (r_rem),
      .i_dvd_msb (r_dvd[WIDTH-1]),
      .i_divisor (r_divisor),
      .o_rem     (w_rem_nxt),
      .o_q       (w_q)
   );

   // The dividend register doubles as the quotient: each step shifts a dividend bit out and a quotient bit in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_rem      <= '0;
         r_dvd      <= '0;
         r_divisor  <= '0;
         r_y        <= '0;
         r_cnt      <= '0;
         r_op       <= 1'b0;
         r_sign     <= 1'b0;
         r_valid    <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_op      <= op;
                  r_sign    <= (op == OP_SIGNED) ? (rn[WIDTH-1] ^ rm[WIDTH-1]) : 1'b0;
                  r_dvd     <= w_abs_rn;
                  r_divisor <= w_abs_rm;
                  r_rem     <= '0;
                  r_cnt     <= '0;
                  if (rm == '0) begin
                     r_y        <= '0;
                     r_div_zero <= 1'b1;
                     r_valid    <= 1'b1;
                     r_state    <= DONE;
                  end else begin
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               r_rem <= w_rem_nxt;
               r_dvd <= {r_dvd[WIDTH-2:0], w_q};
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(WIDTH-1)) r_state <= FIX;
            end
            FIX: begin
               r_y     <= (r_op == OP_SIGNED && r_sign) ? -r_dvd : r_dvd;
               r_valid <= 1'b1;
               r_state <= DONE;
            end
            DONE: begin
               if (ack) begin
                  r_valid    <= 1'b0;
                  r_div_zero <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign start_ready = (r_state == IDLE);
   assign busy        = (r_state != IDLE);
   assign y           = r_y;
   assign valid       = r_valid;
   assign div_zero    = r_div_zero;

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized and directed bench for div_sequencer against an integer-arithmetic reference model.
module tb_div_sequencer;

   localparam int WIDTH = 32;
   localparam int LAT   = WIDTH + 2;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             start_ready;
   logic [WIDTH-1:0] rn = '0;
   logic [WIDTH-1:0] rm = '0;
   logic             op = 1'b0;
   logic [WIDTH-1:0] y;
   logic             valid;
   logic             ack = 1'b0;
   logic             busy;
   logic             div_zero;

   int n_chk  = 0;
   int n_pass = 0;

   div_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .start_ready (start_ready),
      .rn          (rn),
      .rm          (rm),
      .op          (op),
      .y           (y),
      .valid       (valid),
      .ack         (ack),
      .busy        (busy),
      .div_zero    (div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic o);
      longint sa, sb, q;
      if (b == '0) return '0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (o) begin
         if (sa < 0) sa = -sa;
         if (sb < 0) sb = -sb;
      end
      q = sa / sb;
      return q[WIDTH-1:0];
   endfunction

   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic o,
                         input int hold);
      int lat;
      logic [WIDTH-1:0] exp_y;
      exp_y = model(a, b, o);
      @(negedge clk);
      chk("ready_before", start_ready, 1);
      start = 1'b1; rn = a; rm = b; op = o;
      @(posedge clk); #1;
      start = 1'b0; rn = $urandom; rm = $urandom; op = 1'($urandom);
      chk("busy_after_accept", busy, 1);
      lat = 1;
      while (!valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, (b == '0) ? 1 : LAT);
      chk("y", y, exp_y);
      chk("div_zero", div_zero, (b == '0) ? 1 : 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         start = 1'b1;
         @(posedge clk); #1;
         chk("hold_valid", valid, 1);
         chk("hold_y", y, exp_y);
         chk("hold_not_ready", start_ready, 0);
      end
      @(negedge clk);
      start = 1'b0; ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      chk("ack_valid_clr", valid, 0);
      chk("ack_dz_clr", div_zero, 0);
      chk("ack_ready", start_ready, 1);
      chk("ack_busy_clr", busy, 0);
   endtask

   initial begin
      #12;
      chk("rst_y", y, 0);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dz", div_zero, 0);
      chk("rst_ready", start_ready, 1);
      @(negedge clk);
      reset = 1'b0;

      run_op(32'd100, 32'd7, 1'b0, 0);
      run_op(-32'sd100, 32'd7, 1'b0, 0);
      run_op(32'hFFFF_FF9C, -32'sd7, 1'b1, 0);
      run_op(32'd0, 32'd5, 1'b1, 0);
      run_op(32'd42, 32'd0, 1'b0, 0);
      run_op(32'd42, 32'd0, 1'b1, 0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
      run_op(32'h8000_0000, 32'd2, 1'b1, 0);
      run_op(-32'sd9, 32'd2, 1'b0, 10);
      run_op(32'd9, -32'sd4, 1'b0, 0);

      // Abort in the middle of the iteration sequence.
      @(negedge clk);
      start = 1'b1; rn = 32'd1000; rm = 32'd3; op = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_valid", valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ready", start_ready, 1);
      chk("abort_y", y, 0);
      @(negedge clk);
      reset = 1'b0;
      run_op(32'd9, 32'd3, 1'b0, 0);

      for (int k = 0; k < 24; k++) begin
         logic [WIDTH-1:0] a, b;
         a = $urandom;
         case ($urandom_range(3))
            0: b = '0;
            1: b = 32'($urandom_range(15)) - 32'd7;
            2: b = $urandom >> $urandom_range(31);
            default: b = $urandom;
         endcase
         if ($urandom_range(3) == 0) a = a >> $urandom_range(31);
         run_op(a, b, 1'($urandom), int'($urandom_range(2)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got=%0d exp=%0d", n_chk, 0);
      $fatal(1, "timeout");
   end

endmodule
